fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit core, directly upstream of the instruction controller. Holds the program counter and instruction register, fetches one instruction per cycle-sequence over a variable-latency memory read handshake, and splits it into the fields the controller decodes (op_code, ext_op_code, A_index, B_index, immediate). After the controller and datapath finish executing, it applies the controller's pc_src selection to compute the next PC.

---
 rtl/fetch_mem_if.sv | 25 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_mem_if.sv
// Instruction memory read handshake between the fetch stage and instruction memory.
// One request strobe with address; one response strobe with data.
interface fetch_mem_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_valid;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/IR, FETCH-WAIT-ISSUE sequencing over the memory handshake,
// instruction field split and next-PC selection on exec_done.
module fetch_unit #(
  parameter int unsigned           WIDTH      = 16,
  parameter int unsigned           OP_BITS    = 4,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_mem_if.master            mem,
  input  logic                   exec_done,
  input  logic [1:0]             pc_src,
  input  logic [WIDTH-1:0]       reg_b_data,
  output logic [OP_BITS-1:0]     op_code,
  output logic [OP_BITS-1:0]     A_index,
  output logic [OP_BITS-1:0]     ext_op_code,
  output logic [OP_BITS-1:0]     B_index,
  output logic [2*OP_BITS-1:0]   imm,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [ADDR_WIDTH-1:0]  pc_plus1
);

  localparam int unsigned IMM_W = 2 * OP_BITS;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_rd_en;
  logic                  w_issue;
  logic [WIDTH-1:0]      r_ir;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_plus1;
  logic [ADDR_WIDTH-1:0] w_imm_sext;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: w_next_state = S_WAIT;
      S_WAIT:  if (mem.mem_valid) w_next_state = S_ISSUE;
      S_ISSUE: if (exec_done)     w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_rd_en = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      S_FETCH: w_rd_en = 1'b1;
      S_ISSUE: w_issue = 1'b1;
      default: ;
    endcase
  end

  assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);
  assign w_imm_sext = {{(ADDR_WIDTH - IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};

  // Next PC: 01 jump to register B, 11 relative branch, otherwise sequential
  always_comb begin
    w_next_pc = w_pc_plus1;
    case (pc_src)
      2'b01:   w_next_pc = reg_b_data[ADDR_WIDTH-1:0];
      2'b11:   w_next_pc = r_pc + w_imm_sext;
      default: w_next_pc = w_pc_plus1;
    endcase
  end

  // IR loads only on a response in WAIT; PC commits only on exec_done in ISSUE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
    end else begin
      if (r_state == S_WAIT && mem.mem_valid) r_ir <= mem.mem_rdata;
      if (r_state == S_ISSUE && exec_done)    r_pc <= w_next_pc;
    end
  end

  assign mem.mem_rd_en = w_rd_en & reset;
  assign mem.mem_addr  = r_pc;

  assign op_code     = r_ir[WIDTH-1 -: OP_BITS];
  assign A_index     = r_ir[WIDTH-1-OP_BITS -: OP_BITS];
  assign ext_op_code = r_ir[IMM_W-1 -: OP_BITS];
  assign B_index     = r_ir[OP_BITS-1:0];
  assign imm         = r_ir[IMM_W-1:0];
  assign instr_valid = w_issue;
  assign pc          = r_pc;
  assign pc_plus1    = w_pc_plus1;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed instruction table, reset corner cases,
// then randomized instruction stream against a next-PC reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exec_done = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [15:0] reg_b_data = 16'h0000;
  logic [3:0]  op_code, A_index, ext_op_code, B_index;
  logic [7:0]  imm;
  logic        instr_valid;
  logic [15:0] pc, pc_plus1;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_mem_if #(.WIDTH(16), .ADDR_WIDTH(16)) mem_if ();

  fetch_unit #(
    .WIDTH(16), .OP_BITS(4), .ADDR_WIDTH(16), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .mem(mem_if.master),
    .exec_done(exec_done), .pc_src(pc_src), .reg_b_data(reg_b_data),
    .op_code(op_code), .A_index(A_index), .ext_op_code(ext_op_code),
    .B_index(B_index), .imm(imm), .instr_valid(instr_valid),
    .pc(pc), .pc_plus1(pc_plus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;   // expected fetch address
    logic [15:0] word;   // instruction returned by memory
    int          lat;
    int          dly;    // extra ISSUE cycles before exec_done
    logic [1:0]  src;
    logic [15:0] regb;
    bit          spur;   // spurious mem_valid in ISSUE / exec_done in WAIT
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Architectural next-PC rule, plain 16-bit modular arithmetic
  function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [15:0] word,
                                             input logic [1:0] src, input logic [15:0] regb);
    logic [15:0] off;
    off = {{8{word[7]}}, word[7:0]};
    if (src == 2'b01)      return regb;
    else if (src == 2'b11) return cur + off;
    else                   return cur + 16'd1;
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h2F1B) ^ 16'h1357;
  endfunction

  // Entered in the FETCH cycle; leaves in the cycle after exec_done
  task automatic do_instr(input logic [15:0] addr, input logic [15:0] word, input int lat,
                          input int dly, input logic [1:0] src, input logic [15:0] regb,
                          input bit spur);
    logic [15:0] p1;
    p1 = addr + 16'd1;
    check("fetch_rd_en", 32'(mem_if.mem_rd_en), 32'd1);
    check("fetch_addr", 32'(mem_if.mem_addr), 32'(addr));
    check("fetch_iv", 32'(instr_valid), 32'd0);
    mem_if.mem_valid = 1'b0;
    exec_done = spur;
    tick();
    for (int i = 1; i <= lat; i++) begin
      check("wait_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
      check("wait_iv", 32'(instr_valid), 32'd0);
      check("wait_pc", 32'(pc), 32'(addr));
      if (i == lat) begin
        mem_if.mem_valid = 1'b1;
        mem_if.mem_rdata = word;
        exec_done = 1'b0;
      end else begin
        mem_if.mem_valid = 1'b0;
        mem_if.mem_rdata = 16'($urandom);
        exec_done = spur;
        pc_src = 2'($urandom);
        reg_b_data = 16'($urandom);
      end
      tick();
    end
    for (int d = 0; d <= dly; d++) begin
      check("issue_iv", 32'(instr_valid), 32'd1);
      check("issue_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
      check("op_code", 32'(op_code), 32'(word[15:12]));
      check("A_index", 32'(A_index), 32'(word[11:8]));
      check("ext_op_code", 32'(ext_op_code), 32'(word[7:4]));
      check("B_index", 32'(B_index), 32'(word[3:0]));
      check("imm", 32'(imm), 32'(word[7:0]));
      check("issue_pc", 32'(pc), 32'(addr));
      check("pc_plus1", 32'(pc_plus1), 32'(p1));
      mem_if.mem_valid = spur;
      mem_if.mem_rdata = ~word;
      if (d == dly) begin
        exec_done = 1'b1;
        pc_src = src;
        reg_b_data = regb;
      end else begin
        exec_done = 1'b0;
        pc_src = 2'($urandom);
        reg_b_data = 16'($urandom);
      end
      tick();
    end
    exec_done = 1'b0;
    mem_if.mem_valid = 1'b0;
    check("iv_drop", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] w;
    int          lat, dly;
    logic [1:0]  src;
    logic [15:0] regb;
    bit          spur;

    tbl[0]  = '{16'h0000, 16'h0312, 1, 0, 2'b10, 16'h0000, 1'b0};
    tbl[1]  = '{16'h0001, 16'h1000, 1, 0, 2'b00, 16'h0000, 1'b0};
    tbl[2]  = '{16'h0002, 16'h2000, 1, 0, 2'b10, 16'h0000, 1'b0};
    tbl[3]  = '{16'h0003, 16'h3000, 1, 0, 2'b01, 16'h0010, 1'b0};
    tbl[4]  = '{16'h0010, 16'h40FE, 1, 0, 2'b11, 16'h0000, 1'b0};
    tbl[5]  = '{16'h000E, 16'h5555, 2, 1, 2'b01, 16'h00A0, 1'b0};
    tbl[6]  = '{16'h00A0, 16'h6000, 1, 0, 2'b01, 16'hFFFF, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'h7000, 1, 0, 2'b10, 16'h0000, 1'b0};
    tbl[8]  = '{16'h0000, 16'h8105, 4, 2, 2'b11, 16'h0000, 1'b1};
    tbl[9]  = '{16'h0005, 16'h9000, 1, 0, 2'b11, 16'h0000, 1'b1};
    tbl[10] = '{16'h0005, 16'hA080, 2, 0, 2'b11, 16'h0000, 1'b0};
    tbl[11] = '{16'hFF85, 16'hB07F, 3, 1, 2'b11, 16'h0000, 1'b0};

    mem_if.mem_valid = 1'b0;
    mem_if.mem_rdata = 16'h0000;

    // Reset state
    tick();
    tick();
    check("rst_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
    check("rst_iv", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_op", 32'(op_code), 32'h0);
    check("rst_imm", 32'(imm), 32'h0);
    reset = 1'b1;
    #1;

    foreach (tbl[k])
      do_instr(tbl[k].addr, tbl[k].word, tbl[k].lat, tbl[k].dly,
               tbl[k].src, tbl[k].regb, tbl[k].spur);

    // Reset during WAIT with a response arriving while reset is low
    check("rw_fetch_addr", 32'(mem_if.mem_addr), 32'h0004);
    tick();
    check("rw_wait_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
    reset = 1'b0;
    #1;
    check("rw_rst_pc", 32'(pc), 32'h0);
    check("rw_rst_iv", 32'(instr_valid), 32'd0);
    check("rw_rst_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
    mem_if.mem_valid = 1'b1;
    mem_if.mem_rdata = 16'hFFFF;
    tick();
    mem_if.mem_valid = 1'b0;
    check("rw_dropped_op", 32'(op_code), 32'h0);
    check("rw_dropped_imm", 32'(imm), 32'h0);
    reset = 1'b1;
    #1;
    check("rw_restart_rd_en", 32'(mem_if.mem_rd_en), 32'd1);
    check("rw_restart_addr", 32'(mem_if.mem_addr), 32'h0000);
    check("rw_restart_iv", 32'(instr_valid), 32'd0);

    // Reset during ISSUE
    tick();
    check("ri_wait_iv", 32'(instr_valid), 32'd0);
    mem_if.mem_valid = 1'b1;
    mem_if.mem_rdata = 16'hC3A5;
    tick();
    mem_if.mem_valid = 1'b0;
    check("ri_issue_iv", 32'(instr_valid), 32'd1);
    check("ri_issue_op", 32'(op_code), 32'hC);
    reset = 1'b0;
    #1;
    check("ri_rst_iv", 32'(instr_valid), 32'd0);
    check("ri_rst_op", 32'(op_code), 32'h0);
    check("ri_rst_pc", 32'(pc), 32'h0);
    tick();
    reset = 1'b1;
    #1;

    // Randomized instruction stream
    exp_pc = 16'h0000;
    for (int n = 0; n < 150; n++) begin
      w    = mem_word(exp_pc);
      lat  = int'($urandom_range(1, 5));
      dly  = int'($urandom_range(0, 3));
      src  = 2'($urandom);
      regb = 16'($urandom);
      spur = 1'($urandom);
      do_instr(exp_pc, w, lat, dly, src, regb, spur);
      exp_pc = model_next(exp_pc, w, src, regb);
    end
    check("final_addr", 32'(mem_if.mem_addr), 32'(exp_pc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
